cursor_scroll_ctrl: RTL and testbench
=====================================

Name: cursor_scroll_ctrl

Overview:
- Sequences the board cursor and the VGA viewport scroll from the two joystick rockers.
- Converts level direction inputs into clamped, single-step updates with press/hold auto-repeat.
- Drives cursor cell coordinates to the seven-segment display and game logic, and scroll pixel offsets to the VGA pixel generator.
- Has four independent axis channels: cursor X, cursor Y, scroll X, scroll Y.

Parameters:
- GRID_W, 20, board columns; cursor_x range 0..GRID_W-1.
- GRID_H, 15, board rows; cursor_y range 0..GRID_H-1.
- CUR_RST_X, 7, cursor_x reset value.
- CUR_RST_Y, 7, cursor_y reset value.
- MAX_SCROLL_X, 640, maximum scroll_x in pixels.
- MAX_SCROLL_Y, 480, maximum scroll_y in pixels.
- SCROLL_STEP, 8, pixels per scroll step.
- REPEAT_DELAY, 30_000_000, clk cycles from the first step to the first repeat step.
- REPEAT_PERIOD, 10_000_000, clk cycles between subsequent repeat steps.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous, active-high reset.
- enable  in  1  channels active when high.
- move_left, move_right, move_up, move_down  in  1 each  cursor direction levels (rocker 1).
- scroll_left, scroll_right, scroll_up, scroll_down  in  1 each  scroll direction levels (rocker 2).
- cursor_x  out  5  cursor column.
- cursor_y  out  5  cursor row.
- scroll_x  out  10  viewport x offset in pixels.
- scroll_y  out  10  viewport y offset in pixels.
- moved  out  1  one-cycle pulse when cursor_x or cursor_y changed this cycle.

Behaviour:
- Reset: cursor_x=CUR_RST_X, cursor_y=CUR_RST_Y, scroll_x=0, scroll_y=0, moved=0. All channels go to IDLE and timers clear. Reset mid-hold aborts the repeat; the first press after reset release is treated as a new press.
- Per-channel direction decode:
  - neg = left/up, pos = right/down.
  - Exactly one asserted gives dir = -1 or +1.
  - Both or neither asserted gives dir = 0, the "none" condition.
- Channel FSM states: IDLE, DELAY, REPEAT.
  - IDLE: if dir != 0, issue a step and go to DELAY, timer := 0.
  - DELAY: timer increments each cycle. If dir = 0, go to IDLE. At timer == REPEAT_DELAY-1, issue a step, go to REPEAT, timer := 0.
  - REPEAT: timer increments each cycle. If dir = 0, go to IDLE. At timer == REPEAT_PERIOD-1, issue a step, timer := 0.
  - Direction reversal in DELAY or REPEAT (dir changes from -1 to +1 or vice versa between consecutive cycles): issue an immediate step in the new direction, go to DELAY, timer := 0.
- Step latency: a step decided in cycle t appears on the output registers at clock edge t+1 (one-cycle registered latency). Timing example:
  - Press sampled at edge t0 gives the first step visible after edge t0+1.
  - The first repeat step lands REPEAT_DELAY cycles after the first step.
  - Later repeat steps land every REPEAT_PERIOD cycles.
- Cursor arithmetic: +/-1 per step, saturating with no wrap.
  - A decrement at 0 holds the value; an increment at GRID_W-1 (X) or GRID_H-1 (Y) holds the value.
  - A blocked step does not disturb FSM timing.
- Scroll arithmetic: +/-SCROLL_STEP per step, computed at 11 bits, then clamped.
  - Decrement when value < SCROLL_STEP gives 0.
  - Increment when value + SCROLL_STEP > MAX gives MAX.
- moved: high for exactly the cycle in which cursor_x or cursor_y registers take a new, different value. A blocked step does not pulse. Scroll changes never pulse moved.
- Channel independence: all four channels run concurrently. A cursor X and cursor Y step in the same cycle update both outputs and produce one moved pulse.
- enable=0: all channels are forced to IDLE, timers clear, and outputs hold. When enable rises while a direction is held, that counts as a new press with an immediate step.
- Timer width: sized to hold max(REPEAT_DELAY, REPEAT_PERIOD)-1; 25 bits at default values.

Test Plan (REPEAT_DELAY=8, REPEAT_PERIOD=4, SCROLL_STEP=8):
- Reset, then pulse move_right for 1 cycle -> cursor_x 7→8 one edge later, moved pulses once, cursor_y stays 7, no further steps.
- Hold move_down 20 cycles from reset -> cursor_y steps to 8 at the first step, then +1 at 8 and at +4-cycle intervals, giving 8,9,10,11 (four steps). After release, no further change.
- Hold move_left from cursor_x=0 for 16 cycles -> cursor_x stays 0 and moved never asserts. Then hold move_right -> immediate step to 1.
- Assert scroll_left and scroll_right together for 20 cycles -> scroll_x unchanged. Drop scroll_left -> scroll_x 0→8 next edge.
- Hold scroll_down from scroll_y=472 -> 480, then clamps at 480. Hold scroll_up from scroll_y=5 -> 0.
- Hold move_right, reverse to move_left mid-REPEAT, assert rst mid-hold, toggle enable -> reversal steps immediately and restarts the 8-cycle delay. rst restores 7/7/0/0 with moved=0. enable=0 freezes all outputs.

Source files
------------

// File: rtl/cursor_scroll_ctrl.sv
// Cursor and viewport-scroll sequencer: four independent axis channels turn
// rocker levels into clamped single steps with press/hold auto-repeat.

module axis_channel #(
    parameter int REPEAT_DELAY  = 30_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       neg,
    input  logic       pos,
    output logic       step,
    output logic       step_pos,
    output logic [1:0] state_dbg
);
    localparam int MAX_T = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW    = (MAX_T > 2) ? $clog2(MAX_T) : 1;
    localparam logic [TW-1:0] DELAY_END  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_END = TW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic          last_pos, last_pos_n;
    logic          active;

    // Both or neither rocker side asserted counts as no direction.
    assign active    = neg ^ pos;
    assign step_pos  = pos & ~neg;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            timer    <= '0;
            last_pos <= 1'b0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            last_pos <= last_pos_n;
        end
    end

    always_comb begin
        state_n    = state;
        timer_n    = timer;
        last_pos_n = last_pos;
        step       = 1'b0;
        if (!enable) begin
            state_n = ST_IDLE;
            timer_n = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (active) begin
                        step       = 1'b1;
                        state_n    = ST_DELAY;
                        timer_n    = '0;
                        last_pos_n = step_pos;
                    end
                end
                ST_DELAY, ST_REPEAT: begin
                    if (!active) begin
                        state_n = ST_IDLE;
                        timer_n = '0;
                    end else if (step_pos != last_pos) begin
                        // Reversal steps at once and restarts the initial delay.
                        step       = 1'b1;
                        state_n    = ST_DELAY;
                        timer_n    = '0;
                        last_pos_n = step_pos;
                    end else if (state == ST_DELAY && timer == DELAY_END) begin
                        step    = 1'b1;
                        state_n = ST_REPEAT;
                        timer_n = '0;
                    end else if (state == ST_REPEAT && timer == PERIOD_END) begin
                        step    = 1'b1;
                        timer_n = '0;
                    end else begin
                        timer_n = timer + 1'b1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    timer_n = '0;
                end
            endcase
        end
    end
endmodule

module cursor_scroll_ctrl #(
    parameter int GRID_W        = 20,
    parameter int GRID_H        = 15,
    parameter int CUR_RST_X     = 7,
    parameter int CUR_RST_Y     = 7,
    parameter int MAX_SCROLL_X  = 640,
    parameter int MAX_SCROLL_Y  = 480,
    parameter int SCROLL_STEP   = 8,
    parameter int REPEAT_DELAY  = 30_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       move_up,
    input  logic       move_down,
    input  logic       scroll_left,
    input  logic       scroll_right,
    input  logic       scroll_up,
    input  logic       scroll_down,
    output logic [4:0] cursor_x,
    output logic [4:0] cursor_y,
    output logic [9:0] scroll_x,
    output logic [9:0] scroll_y,
    output logic       moved,
    output logic [7:0] dbg_state
);
    localparam logic [4:0]  X_LAST = 5'(GRID_W - 1);
    localparam logic [4:0]  Y_LAST = 5'(GRID_H - 1);
    localparam logic [10:0] SX_MAX = 11'(MAX_SCROLL_X);
    localparam logic [10:0] SY_MAX = 11'(MAX_SCROLL_Y);
    localparam logic [10:0] S_STEP = 11'(SCROLL_STEP);

    logic [3:0] step, step_pos;
    logic [4:0] cx_n, cy_n;
    logic [9:0] sx_n, sy_n;

    axis_channel #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_cx (
        .clk(clk), .rst(rst), .enable(enable), .neg(move_left), .pos(move_right),
        .step(step[0]), .step_pos(step_pos[0]), .state_dbg(dbg_state[1:0]));
    axis_channel #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_cy (
        .clk(clk), .rst(rst), .enable(enable), .neg(move_up), .pos(move_down),
        .step(step[1]), .step_pos(step_pos[1]), .state_dbg(dbg_state[3:2]));
    axis_channel #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_sx (
        .clk(clk), .rst(rst), .enable(enable), .neg(scroll_left), .pos(scroll_right),
        .step(step[2]), .step_pos(step_pos[2]), .state_dbg(dbg_state[5:4]));
    axis_channel #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_sy (
        .clk(clk), .rst(rst), .enable(enable), .neg(scroll_up), .pos(scroll_down),
        .step(step[3]), .step_pos(step_pos[3]), .state_dbg(dbg_state[7:6]));

    function automatic logic [4:0] cursor_next(input logic [4:0] cur, input logic stp,
                                               input logic up, input logic [4:0] last);
        logic [4:0] nxt;
        nxt = cur;
        if (stp) begin
            if (up) begin
                if (cur != last) nxt = cur + 5'd1;
            end else if (cur != 5'd0) begin
                nxt = cur - 5'd1;
            end
        end
        return nxt;
    endfunction

    // Scroll math runs at 11 bits so the sum cannot wrap before clamping.
    function automatic logic [9:0] scroll_next(input logic [9:0] cur, input logic stp,
                                               input logic up, input logic [10:0] max_v);
        logic [10:0] wide, sum, diff, nxt;
        wide = {1'b0, cur};
        sum  = wide + S_STEP;
        diff = wide - S_STEP;
        nxt  = wide;
        if (stp) begin
            if (up) nxt = (sum > max_v) ? max_v : sum;
            else    nxt = (wide < S_STEP) ? 11'd0 : diff;
        end
        return nxt[9:0];
    endfunction

    always_comb begin
        cx_n = cursor_next(cursor_x, step[0], step_pos[0], X_LAST);
        cy_n = cursor_next(cursor_y, step[1], step_pos[1], Y_LAST);
        sx_n = scroll_next(scroll_x, step[2], step_pos[2], SX_MAX);
        sy_n = scroll_next(scroll_y, step[3], step_pos[3], SY_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cursor_x <= 5'(CUR_RST_X);
            cursor_y <= 5'(CUR_RST_Y);
            scroll_x <= '0;
            scroll_y <= '0;
            moved    <= 1'b0;
        end else begin
            cursor_x <= cx_n;
            cursor_y <= cy_n;
            scroll_x <= sx_n;
            scroll_y <= sy_n;
            moved    <= (cx_n != cursor_x) || (cy_n != cursor_y);
        end
    end
endmodule

// File: tb/tb_cursor_scroll_ctrl.sv
// Bench for cursor_scroll_ctrl with short repeat timing; expected output words
// are queued per cycle from a press-counter model and compared after each edge.

module tb_cursor_scroll_ctrl;
    localparam int T_DELAY  = 8;
    localparam int T_PERIOD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b1;
    logic move_left = 1'b0, move_right = 1'b0, move_up = 1'b0, move_down = 1'b0;
    logic scroll_left = 1'b0, scroll_right = 1'b0, scroll_up = 1'b0, scroll_down = 1'b0;
    logic [4:0] cursor_x, cursor_y;
    logic [9:0] scroll_x, scroll_y;
    logic       moved;
    logic [7:0] dbg_state;

    logic [30:0] exp_q[$];
    logic [30:0] got, exp_v;
    int checks = 0;
    int errors = 0;

    int ex_cx = 7, ex_cy = 7, ex_sx = 0, ex_sy = 0;
    logic ex_mv = 1'b0;
    int cnt[4];
    int last[4];

    cursor_scroll_ctrl #(
        .REPEAT_DELAY(T_DELAY),
        .REPEAT_PERIOD(T_PERIOD)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .move_left(move_left), .move_right(move_right), .move_up(move_up), .move_down(move_down),
        .scroll_left(scroll_left), .scroll_right(scroll_right),
        .scroll_up(scroll_up), .scroll_down(scroll_down),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .scroll_x(scroll_x), .scroll_y(scroll_y),
        .moved(moved), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic int dir_of(input logic n, input logic p);
        if (n && !p) return -1;
        if (p && !n) return 1;
        return 0;
    endfunction

    // Press model: cnt counts cycles since the press began; steps fall at 0 and
    // at T_DELAY + m*T_PERIOD.
    task automatic model_push();
        int d[4];
        bit st[4];
        int old_cx, old_cy;
        d[0] = dir_of(move_left, move_right);
        d[1] = dir_of(move_up, move_down);
        d[2] = dir_of(scroll_left, scroll_right);
        d[3] = dir_of(scroll_up, scroll_down);
        for (int c = 0; c < 4; c++) begin
            st[c] = 1'b0;
            if (rst || !enable || d[c] == 0) begin
                last[c] = 0;
                cnt[c]  = 0;
            end else if (d[c] != last[c]) begin
                st[c]   = 1'b1;
                cnt[c]  = 0;
                last[c] = d[c];
            end else begin
                cnt[c]++;
                if (cnt[c] >= T_DELAY && (cnt[c] - T_DELAY) % T_PERIOD == 0) st[c] = 1'b1;
            end
        end
        if (rst) begin
            ex_cx = 7; ex_cy = 7; ex_sx = 0; ex_sy = 0; ex_mv = 1'b0;
        end else begin
            old_cx = ex_cx;
            old_cy = ex_cy;
            if (st[0]) ex_cx = (ex_cx + d[0] < 0) ? 0 : (ex_cx + d[0] > 19) ? 19 : ex_cx + d[0];
            if (st[1]) ex_cy = (ex_cy + d[1] < 0) ? 0 : (ex_cy + d[1] > 14) ? 14 : ex_cy + d[1];
            if (st[2]) ex_sx = (ex_sx + 8 * d[2] < 0) ? 0 : (ex_sx + 8 * d[2] > 640) ? 640 : ex_sx + 8 * d[2];
            if (st[3]) ex_sy = (ex_sy + 8 * d[3] < 0) ? 0 : (ex_sy + 8 * d[3] > 480) ? 480 : ex_sy + 8 * d[3];
            ex_mv = (ex_cx != old_cx) || (ex_cy != old_cy);
        end
        exp_q.push_back({5'(ex_cx), 5'(ex_cy), 10'(ex_sx), 10'(ex_sy), ex_mv});
    endtask

    task automatic test_reset();
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rst = 1'b1;
            move_right = 1'b1;
            scroll_down = 1'b1;
            model_push();
            @(posedge clk); #1;
            got = {cursor_x, cursor_y, scroll_x, scroll_y, moved};
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL reset k=%0d: got %h expected %h", k, got, exp_v);
            end
        end
        checks++;
        if (dbg_state !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got %h expected 00", dbg_state);
        end
        rst = 1'b0;
        move_right = 1'b0;
        scroll_down = 1'b0;
    endtask

    task automatic test_single_press();
        for (int k = 0; k < 13; k++) begin
            move_right = (k == 0);
            model_push();
            @(posedge clk); #1;
            got = {cursor_x, cursor_y, scroll_x, scroll_y, moved};
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL single_press k=%0d: got %h expected %h", k, got, exp_v);
            end
        end
    endtask

    task automatic test_hold_down();
        for (int k = 0; k < 30; k++) begin
            move_down = (k < 20);
            model_push();
            @(posedge clk); #1;
            got = {cursor_x, cursor_y, scroll_x, scroll_y, moved};
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL hold_down k=%0d: got %h expected %h", k, got, exp_v);
            end
        end
        checks++;
        if (cursor_y !== 5'd11) begin
            errors++;
            $display("FAIL hold_down_final: got %0d expected 11", cursor_y);
        end
    endtask

    task automatic test_clamp_left();
        for (int k = 0; k < 64; k++) begin
            rst = (k == 0);
            move_left = (k >= 1 && k <= 40) || (k >= 43 && k <= 58);
            move_right = (k == 60);
            model_push();
            @(posedge clk); #1;
            got = {cursor_x, cursor_y, scroll_x, scroll_y, moved};
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL clamp_left k=%0d: got %h expected %h", k, got, exp_v);
            end
        end
    endtask

    task automatic test_clamp_right();
        for (int k = 0; k < 100; k++) begin
            move_right = (k < 96);
            move_down = (k < 96);
            model_push();
            @(posedge clk); #1;
            got = {cursor_x, cursor_y, scroll_x, scroll_y, moved};
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL clamp_right k=%0d: got %h expected %h", k, got, exp_v);
            end
        end
        checks++;
        if (cursor_x !== 5'd19 || cursor_y !== 5'd14) begin
            errors++;
            $display("FAIL clamp_right_final: got %0d/%0d expected 19/14", cursor_x, cursor_y);
        end
    endtask

    task automatic test_scroll_both();
        for (int k = 0; k < 24; k++) begin
            scroll_left = (k < 20);
            scroll_right = (k <= 20);
            model_push();
            @(posedge clk); #1;
            got = {cursor_x, cursor_y, scroll_x, scroll_y, moved};
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL scroll_both k=%0d: got %h expected %h", k, got, exp_v);
            end
        end
    endtask

    task automatic test_scroll_clamp();
        for (int k = 0; k < 526; k++) begin
            scroll_down = (k < 260);
            scroll_up = (k >= 262 && k < 522);
            scroll_left = (k >= 522);
            model_push();
            @(posedge clk); #1;
            got = {cursor_x, cursor_y, scroll_x, scroll_y, moved};
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL scroll_clamp k=%0d: got %h expected %h", k, got, exp_v);
            end
            if (k == 259) begin
                checks++;
                if (scroll_y !== 10'd480) begin
                    errors++;
                    $display("FAIL scroll_max: got %0d expected 480", scroll_y);
                end
            end
        end
        scroll_left = 1'b0;
    endtask

    task automatic test_reversal();
        for (int k = 0; k < 34; k++) begin
            rst = (k == 0);
            move_right = (k >= 1 && k < 15);
            move_down = (k >= 1 && k < 15);
            move_left = (k >= 15 && k < 32);
            model_push();
            @(posedge clk); #1;
            got = {cursor_x, cursor_y, scroll_x, scroll_y, moved};
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL reversal k=%0d: got %h expected %h", k, got, exp_v);
            end
        end
    endtask

    task automatic test_rst_mid_hold();
        for (int k = 0; k < 30; k++) begin
            move_right = (k < 26);
            scroll_right = (k < 26);
            rst = (k == 10 || k == 11);
            model_push();
            @(posedge clk); #1;
            got = {cursor_x, cursor_y, scroll_x, scroll_y, moved};
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL rst_mid_hold k=%0d: got %h expected %h", k, got, exp_v);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_enable();
        for (int k = 0; k < 32; k++) begin
            move_up = (k < 28);
            scroll_down = (k < 28);
            enable = !(k >= 5 && k < 15);
            model_push();
            @(posedge clk); #1;
            got = {cursor_x, cursor_y, scroll_x, scroll_y, moved};
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL enable k=%0d: got %h expected %h", k, got, exp_v);
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 16; k++) begin
            move_left = (k % 2 == 0);
            move_up = (k % 4 < 2);
            scroll_up = (k % 3 == 0);
            model_push();
            @(posedge clk); #1;
            got = {cursor_x, cursor_y, scroll_x, scroll_y, moved};
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL back_to_back k=%0d: got %h expected %h", k, got, exp_v);
            end
        end
        move_left = 1'b0;
        move_up = 1'b0;
        scroll_up = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 200; k++) begin
            move_left = ($urandom_range(0, 3) == 0);
            move_right = ($urandom_range(0, 2) != 0);
            move_up = ($urandom_range(0, 1) == 0);
            move_down = ($urandom_range(0, 3) == 0);
            scroll_left = ($urandom_range(0, 3) == 0);
            scroll_right = ($urandom_range(0, 1) == 0);
            scroll_up = ($urandom_range(0, 2) == 0);
            scroll_down = ($urandom_range(0, 1) == 0);
            enable = ($urandom_range(0, 15) != 0);
            model_push();
            @(posedge clk); #1;
            got = {cursor_x, cursor_y, scroll_x, scroll_y, moved};
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL random k=%0d: got %h expected %h", k, got, exp_v);
            end
        end
        enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_hold_down();
        test_clamp_left();
        test_clamp_right();
        test_scroll_both();
        test_scroll_clamp();
        test_reversal();
        test_rst_mid_hold();
        test_enable();
        test_back_to_back();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
